// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-bus master and MEM/WB writeback register.
// Optional MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_access_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_alu_result,
    input  logic        mem_wr_bck_en,
    input  logic [4:0]  mem_wr_reg_addr,
    input  logic [31:0] mem_pc,
    input  logic [2:0]  ex_mem_loadtype,
    input  logic [1:0]  ex_mem_storetype,
    input  logic [31:0] ex_mem_store_data,
    input  logic        ex_mem_isload,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        stall_req_mem,
    output logic        wb_wr_en,
    output logic [4:0]  wb_wr_reg_addr,
    output logic [31:0] wb_wr_data,
    output logic [31:0] wb_pc,
`ifdef MISALIGN_TRAP_EN
    output logic        mem_misalign,
`endif
    output logic        mem_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_abort;
    logic        r_tmo;
    logic [2:0]  r_ltype;
    logic [1:0]  r_lane;
    logic [31:0] r_ldata;
`ifdef MISALIGN_TRAP_EN
    logic        r_mis;
    logic        w_misalign;
`endif

    logic        w_access;
    logic        w_word;
    logic        w_stall;
    logic        w_tmo;
    logic [1:0]  w_lane;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_access = (ex_mem_loadtype != 3'd0) || (ex_mem_storetype != 2'd0);
    assign w_word   = (ex_mem_loadtype == 3'd3) || (ex_mem_storetype == 2'd3);
    assign w_lane   = w_word ? 2'b00 : mem_alu_result[1:0];
    assign w_stall  = ((r_state == S_IDLE) && w_access) || (r_state == S_BUSY);
    assign w_tmo    = (TMO != 8'd0) && (r_cnt == TMO - 8'd1);

    assign stall_req_mem = w_stall;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign =
        (((ex_mem_loadtype == 3'd2) || (ex_mem_loadtype == 3'd5) ||
          (ex_mem_storetype == 2'd2)) && mem_alu_result[0]) ||
        (w_word && (mem_alu_result[1:0] != 2'b00));
`endif

    // Byte enables and lane-replicated write data for the store type
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex_mem_store_data;
        unique case (ex_mem_storetype)
            2'd1: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{ex_mem_store_data[7:0]}};
            end
            2'd2: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ex_mem_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = 8'(dbus_rdata >> {r_lane, 3'b000});
    assign w_half = r_lane[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

    // Align and extend the returned word for the latched load type
    always_comb begin
        w_ext = dbus_rdata;
        unique case (r_ltype)
            3'd1:    w_ext = {{24{w_byte[7]}}, w_byte};
            3'd2:    w_ext = {{16{w_half[15]}}, w_half};
            3'd4:    w_ext = {24'd0, w_byte};
            3'd5:    w_ext = {16'd0, w_half};
            default: w_ext = dbus_rdata;
        endcase
    end

    // Transaction FSM: issue request, wait for ack or timeout, retire
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_abort    <= 1'b0;
            r_tmo      <= 1'b0;
            r_ltype    <= 3'd0;
            r_lane     <= 2'd0;
            r_ldata    <= 32'd0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'd0;
            dbus_be    <= 4'd0;
            dbus_wdata <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            r_mis      <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_cnt   <= 8'd0;
                        r_ltype <= ex_mem_loadtype;
                        r_lane  <= w_lane;
`ifdef MISALIGN_TRAP_EN
                        if (w_misalign) begin
                            r_abort <= 1'b1;
                            r_mis   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
`else
                        begin
`endif
                            dbus_req   <= 1'b1;
                            dbus_we    <= ex_mem_storetype != 2'd0;
                            dbus_addr  <= {mem_alu_result[31:2], 2'b00};
                            dbus_be    <= w_be;
                            dbus_wdata <= w_wdata;
                            r_state    <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        r_ldata  <= w_ext;
                        r_state  <= S_DONE;
                    end else if (w_tmo) begin
                        dbus_req <= 1'b0;
                        r_abort  <= 1'b1;
                        r_tmo    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_abort <= 1'b0;
                    r_tmo   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                    r_mis   <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // MEM/WB register: update when not stalled, bubble otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wr_en       <= 1'b0;
            wb_wr_reg_addr <= 5'd0;
            wb_wr_data     <= 32'd0;
            wb_pc          <= 32'd0;
            mem_bus_err    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mem_misalign   <= 1'b0;
`endif
        end else if (!w_stall) begin
            wb_wr_en       <= mem_wr_bck_en && !r_abort;
            wb_wr_reg_addr <= mem_wr_reg_addr;
            wb_wr_data     <= ex_mem_isload ? r_ldata : mem_alu_result;
            wb_pc          <= mem_pc;
            mem_bus_err    <= r_tmo;
`ifdef MISALIGN_TRAP_EN
            mem_misalign   <= r_mis;
`endif
        end else begin
            wb_wr_en    <= 1'b0;
            mem_bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mem_misalign <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized bench for mem_access_unit with an
// instruction-level reference model and per-cycle output comparison.
module tb_mem_access_unit;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_alu_result;
    logic        mem_wr_bck_en;
    logic [4:0]  mem_wr_reg_addr;
    logic [31:0] mem_pc;
    logic [2:0]  ex_mem_loadtype;
    logic [1:0]  ex_mem_storetype;
    logic [31:0] ex_mem_store_data;
    logic        ex_mem_isload;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        stall_req_mem;
    logic        wb_wr_en;
    logic [4:0]  wb_wr_reg_addr;
    logic [31:0] wb_wr_data;
    logic [31:0] wb_pc;
    logic        mem_bus_err;
`ifdef MISALIGN_TRAP_EN
    logic        mem_misalign;
    logic        e_mis = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(.ACK_TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_alu_result    (mem_alu_result),
        .mem_wr_bck_en     (mem_wr_bck_en),
        .mem_wr_reg_addr   (mem_wr_reg_addr),
        .mem_pc            (mem_pc),
        .ex_mem_loadtype   (ex_mem_loadtype),
        .ex_mem_storetype  (ex_mem_storetype),
        .ex_mem_store_data (ex_mem_store_data),
        .ex_mem_isload     (ex_mem_isload),
        .dbus_req          (dbus_req),
        .dbus_we           (dbus_we),
        .dbus_addr         (dbus_addr),
        .dbus_be           (dbus_be),
        .dbus_wdata        (dbus_wdata),
        .dbus_ack          (dbus_ack),
        .dbus_rdata        (dbus_rdata),
        .stall_req_mem     (stall_req_mem),
        .wb_wr_en          (wb_wr_en),
        .wb_wr_reg_addr    (wb_wr_reg_addr),
        .wb_wr_data        (wb_wr_data),
        .wb_pc             (wb_pc),
`ifdef MISALIGN_TRAP_EN
        .mem_misalign      (mem_misalign),
`endif
        .mem_bus_err       (mem_bus_err)
    );

    int n_chk   = 0;
    int n_pass  = 0;
    int n_stall = 0;

    // expected outputs for the current cycle
    logic        e_stall = 1'b0;
    logic        e_req   = 1'b0;
    logic        e_we    = 1'b0;
    logic [31:0] e_addr  = 32'd0;
    logic [3:0]  e_be    = 4'd0;
    logic [31:0] e_wdata = 32'd0;
    logic        e_wb_en = 1'b0;
    logic [4:0]  e_wb_rd = 5'd0;
    logic [31:0] e_wb_d  = 32'd0;
    logic [31:0] e_wb_pc = 32'd0;
    logic        e_err   = 1'b0;
    bit          chk_on  = 1'b0;
    bit          chk_bus = 1'b0;
    bit          chk_wbd = 1'b1;
    bit          force_ack = 1'b0;

    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      nm, act, exp, $time);
    endtask

    // per-cycle comparison against the model's expectations
    always @(negedge clk) begin
        if (chk_on) begin
            check("stall", 32'(stall_req_mem), 32'(e_stall));
            check("req", 32'(dbus_req), 32'(e_req));
            if (chk_bus) begin
                check("we", 32'(dbus_we), 32'(e_we));
                check("addr", dbus_addr, e_addr);
                check("be", 32'(dbus_be), 32'(e_be));
                if (e_we) check("wdata", dbus_wdata, e_wdata);
            end
            check("wb_en", 32'(wb_wr_en), 32'(e_wb_en));
            check("wb_rd", 32'(wb_wr_reg_addr), 32'(e_wb_rd));
            check("wb_pc", wb_pc, e_wb_pc);
            if (chk_wbd) check("wb_data", wb_wr_data, e_wb_d);
            check("bus_err", 32'(mem_bus_err), 32'(e_err));
`ifdef MISALIGN_TRAP_EN
            check("misalign", 32'(mem_misalign), 32'(e_mis));
`endif
        end
    end

    always @(negedge clk) if (stall_req_mem) n_stall++;

    always @(negedge clk) begin
        if (dbus_req) begin
            cap_we    <= dbus_we;
            cap_addr  <= dbus_addr;
            cap_be    <= dbus_be;
            cap_wdata <= dbus_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int size_of(input logic [2:0] lt, input logic [1:0] st);
        if (lt == 3'd1 || lt == 3'd4 || st == 2'd1) return 1;
        if (lt == 3'd2 || lt == 3'd5 || st == 2'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ld_model(input logic [2:0] lt,
                                             input int base, input int sz,
                                             input logic [31:0] w);
        longint v;
        longint m;
        v = longint'({32'd0, w >> (8 * base)});
        m = longint'(1) << (8 * sz);
        v = v % m;
        if ((lt == 3'd1 || lt == 3'd2) && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    // advance one clock; apply the writeback-register expectation
    task automatic tick(input bit upd, input logic en, input logic [31:0] d,
                        input bit err, input bit dok);
        @(posedge clk);
        #1;
        if (upd) begin
            e_wb_en = en;
            e_wb_rd = mem_wr_reg_addr;
            e_wb_d  = d;
            e_wb_pc = mem_pc;
            chk_wbd = dok;
        end else begin
            e_wb_en = 1'b0;
        end
        e_err = err;
`ifdef MISALIGN_TRAP_EN
        e_mis = 1'b0;
`endif
    endtask

    // present one instruction until it retires; lat = BUSY cycle of ack
    // (0 = never), rst_at = assert reset in that BUSY cycle instead
    task automatic run(input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic en, input logic [4:0] rd,
                       input logic [31:0] pc, input int lat,
                       input logic [31:0] rdata, input bit rst_at);
        bit   acc;
        bit   acked;
        int   sz;
        int   base;
        acc  = (lt != 3'd0) || (st != 2'd0);
        sz   = size_of(lt, st);
        base = (int'(a[1:0]) / sz) * sz;
        mem_alu_result    = a;
        mem_wr_bck_en     = en;
        mem_wr_reg_addr   = rd;
        mem_pc            = pc;
        ex_mem_loadtype   = lt;
        ex_mem_storetype  = st;
        ex_mem_store_data = d;
        ex_mem_isload     = lt != 3'd0;
        dbus_ack          = force_ack ? 1'b1 : 1'($urandom % 2);
        dbus_rdata        = $urandom;
        e_stall = acc;
        e_req   = 1'b0;
        chk_bus = 1'b0;
        if (!acc) begin
            tick(1'b1, en, a, 1'b0, 1'b1);
            return;
        end
`ifdef MISALIGN_TRAP_EN
        if ((int'(a[1:0]) % sz) != 0) begin
            tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
            e_stall  = 1'b0;
            dbus_ack = 1'($urandom % 2);
            tick(1'b1, 1'b0, a, 1'b0, 1'b0);
            e_mis = 1'b1;
            return;
        end
`endif
        e_we    = st != 2'd0;
        e_addr  = {a[31:2], 2'b00};
        e_be    = 4'd0;
        e_wdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (lt != 3'd0 || (i >= base && i < base + sz)) e_be[i] = 1'b1;
            e_wdata[8*i +: 8] = d[8*(i % sz) +: 8];
        end
        tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        e_req   = 1'b1;
        chk_bus = 1'b1;
        for (int b = 1; b <= TMO; b++) begin
            if (rst_at && b == lat) begin
                rst      = 1'b1;
                dbus_ack = 1'b0;
                tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
                rst     = 1'b0;
                e_stall = 1'b0;
                e_req   = 1'b0;
                chk_bus = 1'b0;
                e_wb_rd = 5'd0;
                e_wb_d  = 32'd0;
                e_wb_pc = 32'd0;
                check("lit_rst_req", 32'(dbus_req), 32'd0);
                return;
            end
            dbus_ack   = b == lat;
            dbus_rdata = (b == lat) ? rdata : $urandom;
            tick(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
            if (b == lat) break;
        end
        acked      = lat >= 1 && lat <= TMO;
        dbus_ack   = 1'($urandom % 2);
        dbus_rdata = $urandom;
        e_req   = 1'b0;
        e_stall = 1'b0;
        chk_bus = 1'b0;
        tick(1'b1, en && acked,
             (lt != 3'd0) ? ld_model(lt, base, sz, rdata) : a,
             !acked, acked);
    endtask

    int s0;

    initial begin
        rst = 1'b1;
        mem_alu_result = 32'd0;
        mem_wr_bck_en = 1'b0;
        mem_wr_reg_addr = 5'd0;
        mem_pc = 32'd0;
        ex_mem_loadtype = 3'd0;
        ex_mem_storetype = 2'd0;
        ex_mem_store_data = 32'd0;
        ex_mem_isload = 1'b0;
        dbus_ack = 1'b0;
        dbus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        s0 = n_stall;
        run(3'd3, 2'd0, 32'h100, 32'd0, 1'b1, 5'd1, 32'h1000, 2,
            32'hDEADBEEF, 1'b0);
        check("lit_lw_data", wb_wr_data, 32'hDEADBEEF);
        check("lit_lw_en", 32'(wb_wr_en), 32'd1);
        check("lit_lw_stalls", 32'(n_stall - s0), 32'd3);

        run(3'd1, 2'd0, 32'h103, 32'd0, 1'b1, 5'd2, 32'h1004, 1,
            32'h80112233, 1'b0);
        check("lit_lb", wb_wr_data, 32'hFFFFFF80);
        run(3'd4, 2'd0, 32'h103, 32'd0, 1'b1, 5'd3, 32'h1008, 1,
            32'h80112233, 1'b0);
        check("lit_lbu", wb_wr_data, 32'h00000080);

        run(3'd0, 2'd2, 32'h202, 32'h0000ABCD, 1'b0, 5'd0, 32'h100C, 1,
            32'd0, 1'b0);
        check("lit_sh_we", 32'(cap_we), 32'd1);
        check("lit_sh_be", 32'(cap_be), 32'hC);
        check("lit_sh_wdata", cap_wdata, 32'hABCDABCD);
        check("lit_sh_addr", cap_addr, 32'h200);
        check("lit_sh_en", 32'(wb_wr_en), 32'd0);

        s0 = n_stall;
        run(3'd0, 2'd0, 32'h55, 32'd0, 1'b1, 5'd4, 32'h1010, 1,
            32'd0, 1'b0);
        check("lit_add_data", wb_wr_data, 32'h55);
        check("lit_add_stalls", 32'(n_stall - s0), 32'd0);

        run(3'd3, 2'd0, 32'h300, 32'd0, 1'b1, 5'd5, 32'h1014, 0,
            32'd0, 1'b0);
        check("lit_tmo_err", 32'(mem_bus_err), 32'd1);
        check("lit_tmo_en", 32'(wb_wr_en), 32'd0);

        run(3'd2, 2'd0, 32'h402, 32'd0, 1'b1, 5'd6, 32'h1018, TMO,
            32'h8001_7FFF, 1'b0);
        check("lit_last_ack", wb_wr_data, 32'hFFFF8001);
        run(3'd0, 2'd3, 32'h500, 32'h12345678, 1'b1, 5'd7, 32'h101C, 0,
            32'd0, 1'b0);

        run(3'd3, 2'd0, 32'h600, 32'd0, 1'b1, 5'd8, 32'h1020, 3,
            32'd0, 1'b1);
        force_ack = 1'b1;
        run(3'd0, 2'd0, 32'h77, 32'd0, 1'b1, 5'd9, 32'h1024, 1,
            32'd0, 1'b0);
        force_ack = 1'b0;

`ifdef MISALIGN_TRAP_EN
        run(3'd3, 2'd0, 32'h101, 32'd0, 1'b1, 5'd10, 32'h1028, 1,
            32'd0, 1'b0);
        check("lit_mis", 32'(mem_misalign), 32'd1);
        check("lit_mis_en", 32'(wb_wr_en), 32'd0);
`endif

        for (int n = 0; n < 150; n++) begin
            int          k;
            logic [2:0]  lt;
            logic [1:0]  st;
            k  = $urandom_range(0, 9);
            lt = 3'd0;
            st = 2'd0;
            if (k >= 3 && k < 7) lt = 3'($urandom_range(1, 5));
            else if (k >= 7) st = 2'($urandom_range(1, 3));
            run(lt, st, $urandom, $urandom, 1'($urandom % 2),
                5'($urandom), $urandom, $urandom_range(1, 4),
                $urandom, 1'b0);
        end

        run(3'd0, 2'd0, 32'h1, 32'd0, 1'b1, 5'd1, 32'h2000, 1,
            32'd0, 1'b0);
        run(3'd0, 2'd0, 32'h2, 32'd0, 1'b0, 5'd2, 32'h2004, 1,
            32'd0, 1'b0);
        @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
